// File: rtl/mult_pipe.sv
// mult_pipe: pipelined RV32M integer multiply unit (MUL/MULH/MULHSU/MULHU).
// The 64-bit product is built one multiplier chunk per stage. Each op carries
// an opaque tag. Results leave through a valid/ready handshake, and a stall
// freezes the whole pipe.
// Optional feature macro: MULT_SQUASH_EN. When it is defined, the squash input
// kills every in-flight op. When it is undefined, squash is ignored.
module mult_pipe #(
   parameter int NUM_STAGES = 4,
   parameter int TAG_W      = 16,
   localparam int XLEN      = 32,
   localparam int FUNC_W    = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_opa,
   input  logic [XLEN-1:0]   in_opb,
   input  logic [FUNC_W-1:0] in_func,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              squash,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              busy
);

   localparam int DW = 2 * XLEN;

   // Function encodings shared with the issue logic.
   localparam logic [FUNC_W-1:0] ALU_MUL    = 4'h0;
   localparam logic [FUNC_W-1:0] ALU_MULH   = 4'h1;
   localparam logic [FUNC_W-1:0] ALU_MULHSU = 4'h2;
   localparam logic [FUNC_W-1:0] ALU_MULHU  = 4'h3;

   // Multiplicand extension: signed for all variants except MULHU.
   function automatic logic [DW-1:0] ext_opa(input logic [FUNC_W-1:0] f,
                                             input logic [XLEN-1:0]   a);
      logic [DW-1:0] r;
      case (f)
         ALU_MUL, ALU_MULH, ALU_MULHSU: r = {{XLEN{a[XLEN-1]}}, a};
         default:                       r = {{XLEN{1'b0}}, a};
      endcase
      return r;
   endfunction

   // Multiplier extension: signed only for MUL and MULH.
   function automatic logic [DW-1:0] ext_opb(input logic [FUNC_W-1:0] f,
                                             input logic [XLEN-1:0]   b);
      logic [DW-1:0] r;
      case (f)
         ALU_MUL, ALU_MULH: r = {{XLEN{b[XLEN-1]}}, b};
         default:           r = {{XLEN{1'b0}}, b};
      endcase
      return r;
   endfunction

   // Product half selection. An unknown func still completes, with a marker value.
   function automatic logic [XLEN-1:0] sel_result(input logic [FUNC_W-1:0] f,
                                                  input logic [DW-1:0]     p);
      logic [XLEN-1:0] r;
      case (f)
         ALU_MUL:                          r = p[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU:  r = p[DW-1:XLEN];
         default:                          r = 32'hfacebeec;
      endcase
      return r;
   endfunction

   logic              kill_s;
   logic              stall_s;
   logic [DW-1:0]     ext_a_s;
   logic [DW-1:0]     ext_b_s;
   logic              fin_valid_s;
   logic [FUNC_W-1:0] fin_func_s;
   logic [TAG_W-1:0]  fin_tag_s;
   logic [DW-1:0]     fin_partial_s;
   logic [DW-1:0]     fin_mcand_s;
   logic [DW-1:0]     fin_mplier_s;
   logic [DW-1:0]     fin_product_s;
   logic              mid_busy_s;
   logic              out_valid_r;
   logic [XLEN-1:0]   out_result_r;
   logic [TAG_W-1:0]  out_tag_r;

`ifdef MULT_SQUASH_EN
   assign kill_s = squash;
`else
   logic unused_squash_s;
   assign kill_s          = 1'b0;
   assign unused_squash_s = squash;
`endif

   assign stall_s  = out_valid_r & ~out_ready;
   assign in_ready = ~stall_s;
   assign ext_a_s  = ext_opa(in_func, in_opa);
   assign ext_b_s  = ext_opb(in_func, in_opb);

   generate
      if (NUM_STAGES == 1) begin : g_single
         // A single stage multiplies the full extended operands in one step.
         assign fin_valid_s   = in_valid;
         assign fin_func_s    = in_func;
         assign fin_tag_s     = in_tag;
         assign fin_partial_s = {DW{1'b0}};
         assign fin_mcand_s   = ext_a_s;
         assign fin_mplier_s  = ext_b_s;
         assign mid_busy_s    = 1'b0;
      end else begin : g_multi
         localparam int NM = NUM_STAGES - 1;
         localparam int C  = DW / NUM_STAGES;
         localparam logic [DW-1:0] CHUNK_MASK = {DW{1'b1}} >> (DW - C);

         logic              st_valid_r   [NM];
         logic [FUNC_W-1:0] st_func_r    [NM];
         logic [TAG_W-1:0]  st_tag_r     [NM];
         logic [DW-1:0]     st_partial_r [NM];
         logic [DW-1:0]     st_mcand_r   [NM];
         logic [DW-1:0]     st_mplier_r  [NM];

         // Intermediate stages: each folds one C-bit multiplier chunk into the partial.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               for (int k = 0; k < NM; k++) begin
                  st_valid_r[k]   <= 1'b0;
                  st_func_r[k]    <= {FUNC_W{1'b0}};
                  st_tag_r[k]     <= {TAG_W{1'b0}};
                  st_partial_r[k] <= {DW{1'b0}};
                  st_mcand_r[k]   <= {DW{1'b0}};
                  st_mplier_r[k]  <= {DW{1'b0}};
               end
            end else if (kill_s) begin
               for (int k = 0; k < NM; k++) begin
                  st_valid_r[k] <= 1'b0;
               end
            end else if (!stall_s) begin
               st_valid_r[0]   <= in_valid;
               st_func_r[0]    <= in_func;
               st_tag_r[0]     <= in_tag;
               st_partial_r[0] <= ext_a_s * (ext_b_s & CHUNK_MASK);
               st_mcand_r[0]   <= ext_a_s << C;
               st_mplier_r[0]  <= ext_b_s >> C;
               for (int k = 1; k < NM; k++) begin
                  st_valid_r[k]   <= st_valid_r[k-1];
                  st_func_r[k]    <= st_func_r[k-1];
                  st_tag_r[k]     <= st_tag_r[k-1];
                  st_partial_r[k] <= st_partial_r[k-1]
                                     + st_mcand_r[k-1] * (st_mplier_r[k-1] & CHUNK_MASK);
                  st_mcand_r[k]   <= st_mcand_r[k-1] << C;
                  st_mplier_r[k]  <= st_mplier_r[k-1] >> C;
               end
            end
         end

         // Any valid op in the intermediate stages keeps the unit busy.
         always_comb begin
            mid_busy_s = 1'b0;
            for (int k = 0; k < NM; k++) begin
               mid_busy_s = mid_busy_s | st_valid_r[k];
            end
         end

         // The remaining multiplier holds only the last chunk, so the full multiply
         // here is the same as multiplying by that chunk.
         assign fin_valid_s   = st_valid_r[NM-1];
         assign fin_func_s    = st_func_r[NM-1];
         assign fin_tag_s     = st_tag_r[NM-1];
         assign fin_partial_s = st_partial_r[NM-1];
         assign fin_mcand_s   = st_mcand_r[NM-1];
         assign fin_mplier_s  = st_mplier_r[NM-1];
      end
   endgenerate

   assign fin_product_s = fin_partial_s + fin_mcand_s * fin_mplier_s;

   // Output stage: the last chunk plus half selection, registered behind the handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_r  <= 1'b0;
         out_result_r <= {XLEN{1'b0}};
         out_tag_r    <= {TAG_W{1'b0}};
      end else if (kill_s) begin
         out_valid_r <= 1'b0;
      end else if (!stall_s) begin
         out_valid_r <= fin_valid_s;
         if (fin_valid_s) begin
            out_result_r <= sel_result(fin_func_s, fin_product_s);
            out_tag_r    <= fin_tag_s;
         end
      end
   end

   assign out_valid  = out_valid_r;
   assign out_result = out_result_r;
   assign out_tag    = out_tag_r;
   assign busy       = out_valid_r | mid_busy_s;

endmodule

// File: tb/tb_mult_pipe.sv
// tb_mult_pipe: directed checks on a 4-stage mult_pipe, followed by a random
// sweep of 1-, 2- and 8-stage instances against a reference multiply.
`timescale 1ns/1ps
module tb_mult_pipe;

   localparam logic [3:0] F_MUL    = 4'h0;
   localparam logic [3:0] F_MULH   = 4'h1;
   localparam logic [3:0] F_MULHSU = 4'h2;
   localparam logic [3:0] F_MULHU  = 4'h3;
   localparam int NOPS = 1000;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, squash, out_valid, out_ready, busy;
   logic [31:0] in_opa, in_opb, out_result;
   logic [3:0]  in_func;
   logic [15:0] in_tag, out_tag;

   logic        r_valid;
   logic [31:0] r_opa, r_opb;
   logic [3:0]  r_func;
   logic [15:0] r_tag;
   logic        s_rdy [3];
   logic        s_ov  [3];
   logic        s_busy[3];
   logic [31:0] s_res [3];
   logic [15:0] s_tg  [3];

   int n_asrt = 0;
   int n_fail = 0;

   logic [31:0] exp_res [NOPS];
   logic [31:0] op_a    [NOPS];
   logic [31:0] op_b    [NOPS];
   logic [3:0]  op_f    [NOPS];
   int          sw_n    [3];

   always #5 clock = ~clock;

   mult_pipe #(.NUM_STAGES(4), .TAG_W(16)) u4 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_opa(in_opa), .in_opb(in_opb), .in_func(in_func), .in_tag(in_tag),
      .squash(squash), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .busy(busy));

   mult_pipe #(.NUM_STAGES(1), .TAG_W(16)) u1 (
      .clock(clock), .reset(reset), .in_valid(r_valid), .in_ready(s_rdy[0]),
      .in_opa(r_opa), .in_opb(r_opb), .in_func(r_func), .in_tag(r_tag),
      .squash(1'b0), .out_valid(s_ov[0]), .out_ready(1'b1),
      .out_result(s_res[0]), .out_tag(s_tg[0]), .busy(s_busy[0]));

   mult_pipe #(.NUM_STAGES(2), .TAG_W(16)) u2 (
      .clock(clock), .reset(reset), .in_valid(r_valid), .in_ready(s_rdy[1]),
      .in_opa(r_opa), .in_opb(r_opb), .in_func(r_func), .in_tag(r_tag),
      .squash(1'b0), .out_valid(s_ov[1]), .out_ready(1'b1),
      .out_result(s_res[1]), .out_tag(s_tg[1]), .busy(s_busy[1]));

   mult_pipe #(.NUM_STAGES(8), .TAG_W(16)) u8 (
      .clock(clock), .reset(reset), .in_valid(r_valid), .in_ready(s_rdy[2]),
      .in_opa(r_opa), .in_opb(r_opb), .in_func(r_func), .in_tag(r_tag),
      .squash(1'b0), .out_valid(s_ov[2]), .out_ready(1'b1),
      .out_result(s_res[2]), .out_tag(s_tg[2]), .busy(s_busy[2]));

   // Reference model: a full 64-bit multiply of the extended operands.
   function automatic logic [31:0] ref_mul(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [63:0] sa, sb, ua, ub;
      logic [63:0] p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         F_MUL:    begin p = sa * sb; return p[31:0];  end
         F_MULH:   begin p = sa * sb; return p[63:32]; end
         F_MULHSU: begin p = sa * ub; return p[63:32]; end
         F_MULHU:  begin p = ua * ub; return p[63:32]; end
         default:  return 32'hfacebeec;
      endcase
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic v, input logic [31:0] r,
                          input logic [15:0] t);
      if (v) chk(name, {15'd0, out_valid, out_result, out_tag}, {15'd0, 1'b1, r, t});
      else   chk(name, {63'd0, out_valid}, 64'd0);
   endtask

   task automatic drive(input logic v, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] t);
      in_valid = v;
      in_func  = f;
      in_opa   = a;
      in_opb   = b;
      in_tag   = t;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; squash = 1'b0; out_ready = 1'b1;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      r_valid = 1'b0; r_opa = 32'd0; r_opb = 32'd0; r_func = F_MUL; r_tag = 16'd0;
      sw_n[0] = 1; sw_n[1] = 2; sw_n[2] = 8;
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_result_tag", {16'd0, out_result, out_tag}, 64'd0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // MUL 7 x 6: latency of exactly four edges, with the tag returned.
      drive(1'b1, F_MUL, 32'd7, 32'd6, 16'h1234);
      chk("t1_in_ready", {63'd0, in_ready}, 64'd1);
      tick; drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      chk_out("t1_lat0", 1'b0, 32'd0, 16'd0);
      chk("t1_busy", {63'd0, busy}, 64'd1);
      tick; chk_out("t1_lat1", 1'b0, 32'd0, 16'd0);
      tick; chk_out("t1_lat2", 1'b0, 32'd0, 16'd0);
      tick; chk_out("t1_result", 1'b1, 32'd42, 16'h1234);
      tick; chk_out("t1_bubble", 1'b0, 32'd0, 16'd0);

      // Back-to-back signed/unsigned high halves.
      drive(1'b1, F_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0101); tick;
      drive(1'b1, F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0102); tick;
      drive(1'b1, F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0103); tick;
      drive(1'b1, F_MUL,    32'h80000000, 32'd2,        16'h0104); tick;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      chk_out("t2_mulh", 1'b1, 32'h00000000, 16'h0101);
      tick; chk_out("t2_mulhu",  1'b1, 32'hFFFFFFFE, 16'h0102);
      tick; chk_out("t2_mulhsu", 1'b1, 32'hFFFFFFFF, 16'h0103);
      tick; chk_out("t2_mul",    1'b1, 32'h00000000, 16'h0104);
      tick; chk_out("t2_empty",  1'b0, 32'd0, 16'd0);
      chk("t2_busy", {63'd0, busy}, 64'd0);

      // Fill the pipe, then stall for three edges while a new op waits.
      drive(1'b1, F_MUL, 32'd2, 32'd3, 16'h0031); tick;
      drive(1'b1, F_MUL, 32'd4, 32'd5, 16'h0032); tick;
      drive(1'b1, F_MUL, 32'd6, 32'd7, 16'h0033); tick;
      drive(1'b1, F_MUL, 32'd8, 32'd9, 16'h0034); tick;
      chk_out("t3_first", 1'b1, 32'd6, 16'h0031);
      drive(1'b1, F_MUL, 32'd10, 32'd11, 16'h0035);
      out_ready = 1'b0;
      #1;
      chk("t3_in_ready_low", {63'd0, in_ready}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_out($sformatf("t3_frozen%0d", i), 1'b1, 32'd6, 16'h0031);
         chk($sformatf("t3_stall_rdy%0d", i), {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      tick; drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      chk_out("t3_b", 1'b1, 32'd20, 16'h0032);
      tick; chk_out("t3_c", 1'b1, 32'd42, 16'h0033);
      tick; chk_out("t3_d", 1'b1, 32'd72, 16'h0034);
      tick; chk_out("t3_e", 1'b1, 32'd110, 16'h0035);
      tick; chk_out("t3_empty", 1'b0, 32'd0, 16'd0);

      // Squash with three ops in flight and a fourth offered in the same cycle.
      drive(1'b1, F_MUL,   32'd9,        32'd9,  16'h0041); tick;
      drive(1'b1, F_MUL,   32'd10,       32'd10, 16'h0042); tick;
      drive(1'b1, F_MULHU, 32'hFFFFFFFF, 32'd2,  16'h0043); tick;
      drive(1'b1, F_MUL,   32'd3,        32'd3,  16'h0044);
      squash = 1'b1;
      tick;
      squash = 1'b0;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
`ifdef MULT_SQUASH_EN
      chk_out("t4_sq_valid", 1'b0, 32'd0, 16'd0);
      chk("t4_sq_busy", {63'd0, busy}, 64'd0);
      chk("t4_sq_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk_out($sformatf("t4_sq_none%0d", i), 1'b0, 32'd0, 16'd0);
      end
`else
      chk_out("t4_f", 1'b1, 32'd81, 16'h0041);
      tick; chk_out("t4_g", 1'b1, 32'd100, 16'h0042);
      tick; chk_out("t4_h", 1'b1, 32'd1, 16'h0043);
      tick; chk_out("t4_i", 1'b1, 32'd9, 16'h0044);
      tick; chk_out("t4_empty", 1'b0, 32'd0, 16'd0);
`endif

      // Asynchronous reset with two ops in flight, then a fresh op.
      drive(1'b1, F_MUL, 32'd11, 32'd2, 16'h0051); tick;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0); tick; tick;
      drive(1'b1, F_MUL, 32'd12, 32'd2, 16'h0052); tick;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      chk_out("t5_pre", 1'b1, 32'd22, 16'h0051);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_valid", {63'd0, out_valid}, 64'd0);
      chk("t5_async_busy", {63'd0, busy}, 64'd0);
      chk("t5_async_data", {16'd0, out_result, out_tag}, 64'd0);
      tick;
      reset = 1'b0;
      drive(1'b1, F_MUL, 32'd3, 32'd5, 16'h0053); tick;
      drive(1'b0, F_MUL, 32'd0, 32'd0, 16'd0);
      chk_out("t5_lat0", 1'b0, 32'd0, 16'd0);
      tick; chk_out("t5_lat1", 1'b0, 32'd0, 16'd0);
      tick; chk_out("t5_lat2", 1'b0, 32'd0, 16'd0);
      tick; chk_out("t5_result", 1'b1, 32'd15, 16'h0053);

      // Random sweep on 1/2/8-stage instances, one op per cycle.
      for (int i = 0; i < NOPS; i++) begin
         op_a[i] = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
         op_b[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'($urandom);
         op_f[i] = 4'($urandom_range(0, 5));
         exp_res[i] = ref_mul(op_f[i], op_a[i], op_b[i]);
      end
      for (int c = 0; c < NOPS + 8; c++) begin
         if (c < NOPS) begin
            r_valid = 1'b1; r_opa = op_a[c]; r_opb = op_b[c];
            r_func = op_f[c]; r_tag = 16'(c);
         end else begin
            r_valid = 1'b0;
         end
         tick;
         for (int j = 0; j < 3; j++) begin
            int idx;
            idx = c - (sw_n[j] - 1);
            if (idx >= 0 && idx < NOPS)
               chk($sformatf("sweep_n%0d_op%0d", sw_n[j], idx),
                   {15'd0, s_ov[j], s_res[j], s_tg[j]},
                   {15'd0, 1'b1, exp_res[idx], 16'(idx)});
            else
               chk($sformatf("sweep_n%0d_idle_c%0d", sw_n[j], c),
                   {63'd0, s_ov[j]}, 64'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
